// File: rtl/jk_ff_pkg.sv
// Shared types and next-state logic for the multi-mode flip-flop bank.
// Contents:
//   mode_e      - per-bank operating mode (JK, SR, D, T)
//   bit_next_t  - next state of one bit plus its SR-illegal flag
//   next_bit()  - combinational next-state function for one storage bit
package jk_ff_pkg;

    typedef enum logic [1:0] {
        MODE_JK = 2'd0,
        MODE_SR = 2'd1,
        MODE_D  = 2'd2,
        MODE_T  = 2'd3
    } mode_e;

    typedef struct packed {
        logic q;
        logic illegal;
    } bit_next_t;

    // Next state of one bit for the given mode; illegal flags S=R=1 in SR mode,
    // in which case the bit holds.
    function automatic bit_next_t next_bit(input mode_e mode, input logic q,
                                           input logic j, input logic k);
        bit_next_t res;
        res.q       = q;
        res.illegal = 1'b0;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b00:   res.q = q;
                    2'b01:   res.q = 1'b0;
                    2'b10:   res.q = 1'b1;
                    2'b11:   res.q = ~q;
                    default: res.q = q;
                endcase
            end
            MODE_SR: begin
                case ({j, k})
                    2'b00:   res.q = q;
                    2'b01:   res.q = 1'b0;
                    2'b10:   res.q = 1'b1;
                    2'b11: begin
                        res.q       = q;
                        res.illegal = 1'b1;
                    end
                    default: res.q = q;
                endcase
            end
            MODE_D:  res.q = j;
            MODE_T:  res.q = j ? ~q : q;
            default: res.q = q;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// One storage bit of the flip-flop bank.
// Ports:
//   clk, rst (async, active-low), en, mode, j, k  - shared control and bit inputs
//   q        - stored bit (registered)
//   toggled  - q changed at the last edge (registered)
//   change   - q will change at the coming edge (combinational, gated by en)
//   illegal  - S=R=1 seen in SR mode at the coming edge (combinational, gated by en)
import jk_ff_pkg::*;

module jk_ff_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  mode_e mode,
    input  logic  j,
    input  logic  k,
    output logic  q,
    output logic  toggled,
    output logic  change,
    output logic  illegal
);

    logic      q_r;
    logic      toggled_r;
    bit_next_t nxt_s;

    // Next-state evaluation; change/illegal are exported so the top can
    // update its status registers on the same edge as q.
    always_comb begin
        nxt_s   = next_bit(mode, q_r, j, k);
        change  = en & (nxt_s.q ^ q_r);
        illegal = en & nxt_s.illegal;
    end

    // Storage bit and its change flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r       <= RESET_BIT;
            toggled_r <= 1'b0;
        end else if (en) begin
            q_r       <= nxt_s.q;
            toggled_r <= nxt_s.q ^ q_r;
        end else begin
            q_r       <= q_r;
            toggled_r <= 1'b0;
        end
    end

    assign q       = q_r;
    assign toggled = toggled_r;

endmodule

// File: rtl/jk_ff_bank.sv
// Multi-mode flip-flop bank: WIDTH bits acting as JK/SR/D/T flip-flops with
// per-bit change flags, a sticky SR-illegal error and a saturating counter of
// edges on which any bit changed.
// Ports:
//   clk, rst (async, active-low)
//   en        - update enable (0 = hold, toggled forced to 0)
//   mode      - 0=JK 1=SR 2=D 3=T, common to all bits
//   j, k      - per-bit inputs (k unused in D/T)
//   clr_stat  - synchronous clear of err and chg_cnt (a same-edge event wins)
//   q, q_n    - stored state and its complement
//   toggled   - bits that changed at the last edge
//   err       - sticky SR-illegal flag
//   chg_cnt   - saturating count of changing edges
import jk_ff_pkg::*;

module jk_ff_bank #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
    parameter int                 CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clr_stat,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] toggled,
    output logic             err,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    mode_e            mode_s;
    logic [WIDTH-1:0] change_s;
    logic [WIDTH-1:0] illegal_s;
    logic             any_change_s;
    logic             any_illegal_s;
    logic             err_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             err_r;
    logic [CNT_W-1:0] cnt_r;

    assign mode_s = mode_e'(mode);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            jk_ff_cell #(
                .RESET_BIT (RESET_VAL[gi])
            ) u_cell (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .mode    (mode_s),
                .j       (j[gi]),
                .k       (k[gi]),
                .q       (q[gi]),
                .toggled (toggled[gi]),
                .change  (change_s[gi]),
                .illegal (illegal_s[gi])
            );
        end
    endgenerate

    // Status next-state: clear restarts from this edge's events, so a
    // simultaneous illegal or change is not lost.
    always_comb begin
        any_change_s  = |change_s;
        any_illegal_s = |illegal_s;
        err_next_s    = err_r;
        cnt_next_s    = cnt_r;
        if (clr_stat) begin
            err_next_s = any_illegal_s;
            cnt_next_s = any_change_s ? CNT_W'(1) : CNT_W'(0);
        end else begin
            err_next_s = err_r | any_illegal_s;
            if (any_change_s && (cnt_r != CNT_MAX)) begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end else begin
                cnt_next_s = cnt_r;
            end
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            err_r <= err_next_s;
            cnt_r <= cnt_next_s;
        end
    end

    assign q_n     = ~q;
    assign err     = err_r;
    assign chg_cnt = cnt_r;

endmodule

// File: tb/tb_jk_ff_bank.sv
module tb_jk_ff_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic       clr_stat;
    logic [7:0] q;
    logic [7:0] q_n;
    logic [7:0] toggled;
    logic       err;
    logic [7:0] chg_cnt;

    // Second instance for counter saturation
    logic       s_en;
    logic [1:0] s_mode;
    logic [0:0] s_j;
    logic [0:0] s_k;
    logic       s_clr;
    logic [0:0] s_q;
    logic [0:0] s_q_n;
    logic [0:0] s_toggled;
    logic       s_err;
    logic [1:0] s_cnt;

    int n_checks;
    int n_fail;

    jk_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
        .clr_stat(clr_stat), .q(q), .q_n(q_n), .toggled(toggled),
        .err(err), .chg_cnt(chg_cnt)
    );

    jk_ff_bank #(.WIDTH(1), .RESET_VAL(1'b0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(s_en), .mode(s_mode), .j(s_j), .k(s_k),
        .clr_stat(s_clr), .q(s_q), .q_n(s_q_n), .toggled(s_toggled),
        .err(s_err), .chg_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic cycle(input logic e, input logic [1:0] m, input logic [7:0] jj,
                         input logic [7:0] kk, input logic c);
        @(negedge clk);
        en = e; mode = m; j = jj; k = kk; clr_stat = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] eq, input logic [7:0] et,
                             input logic ee, input logic [7:0] ec);
        check_eq({tag, ".q"},       {24'd0, q},       {24'd0, eq});
        check_eq({tag, ".q_n"},     {24'd0, q_n},     {24'd0, ~eq});
        check_eq({tag, ".toggled"}, {24'd0, toggled}, {24'd0, et});
        check_eq({tag, ".err"},     {31'd0, err},     {31'd0, ee});
        check_eq({tag, ".chg_cnt"}, {24'd0, chg_cnt}, {24'd0, ec});
    endtask

    logic [1:0] jk_in  [5];
    logic [7:0] jk_q   [5];
    logic [7:0] jk_tog [5];
    logic [7:0] jk_cnt [5];
    logic [1:0] sat_exp [6];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; en = 1'b0; mode = 2'd0; j = 8'h00; k = 8'h00; clr_stat = 1'b0;
        s_en = 1'b0; s_mode = 2'd3; s_j = 1'b1; s_k = 1'b0; s_clr = 1'b0;

        jk_in[0] = 2'b10; jk_q[0] = 8'h01; jk_tog[0] = 8'h01; jk_cnt[0] = 8'd1;
        jk_in[1] = 2'b01; jk_q[1] = 8'h00; jk_tog[1] = 8'h01; jk_cnt[1] = 8'd2;
        jk_in[2] = 2'b00; jk_q[2] = 8'h00; jk_tog[2] = 8'h00; jk_cnt[2] = 8'd2;
        jk_in[3] = 2'b11; jk_q[3] = 8'h01; jk_tog[3] = 8'h01; jk_cnt[3] = 8'd3;
        jk_in[4] = 2'b11; jk_q[4] = 8'h00; jk_tog[4] = 8'h01; jk_cnt[4] = 8'd4;
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3; sat_exp[5] = 2'd3;

        // Asynchronous reset asserted mid-clock
        #2 rst = 1'b0;
        #1 check_all("reset", 8'hA5, 8'h00, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b1;

        // Disabled edges hold everything
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0);
            check_all("en0_hold", 8'hA5, 8'h00, 1'b0, 8'd0);
        end

        // D mode to zero, then clear counter with en=0
        cycle(1'b1, 2'd2, 8'h00, 8'h00, 1'b0);
        check_all("d_zero", 8'h00, 8'hA5, 1'b0, 8'd1);
        cycle(1'b0, 2'd2, 8'hFF, 8'h00, 1'b1);
        check_all("clr_en0", 8'h00, 8'h00, 1'b0, 8'd0);

        // JK sequence on bit 0
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2'd0, {7'd0, jk_in[i][1]}, {7'd0, jk_in[i][0]}, 1'b0);
            check_all("jk_seq", jk_q[i], jk_tog[i], 1'b0, jk_cnt[i]);
        end

        // SR mode: bit0 illegal holds, bit1 sets
        cycle(1'b1, 2'd1, 8'h03, 8'h01, 1'b0);
        check_all("sr_illegal", 8'h02, 8'h02, 1'b1, 8'd5);
        cycle(1'b1, 2'd1, 8'h00, 8'h00, 1'b1);
        check_all("sr_clr", 8'h02, 8'h00, 1'b0, 8'd0);
        cycle(1'b1, 2'd1, 8'h01, 8'h01, 1'b1);
        check_all("sr_clr_set_wins", 8'h02, 8'h00, 1'b1, 8'd0);

        // D then T
        cycle(1'b1, 2'd2, 8'h3C, 8'h00, 1'b0);
        check_all("d_load", 8'h3C, 8'h3E, 1'b1, 8'd1);
        cycle(1'b1, 2'd3, 8'hFF, 8'h00, 1'b0);
        check_all("t_first", 8'hC3, 8'hFF, 1'b1, 8'd2);
        cycle(1'b1, 2'd3, 8'hFF, 8'h00, 1'b0);
        check_all("t_second", 8'h3C, 8'hFF, 1'b1, 8'd3);

        // Illegal SR while disabled does not set err; clear honoured
        cycle(1'b0, 2'd1, 8'hFF, 8'hFF, 1'b1);
        check_all("sr_en0_clr", 8'h3C, 8'h00, 1'b0, 8'd0);

        // Counter saturation on the CNT_W=2 instance
        @(negedge clk);
        en = 1'b0; clr_stat = 1'b0;
        s_en = 1'b1; s_mode = 2'd3; s_j = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_eq("sat_cnt", {30'd0, s_cnt}, {30'd0, sat_exp[i]});
        end
        @(negedge clk);
        s_en = 1'b0;

        // Async reset mid-run, then first edge after release is a normal update
        cycle(1'b1, 2'd3, 8'hFF, 8'h00, 1'b0);
        check_all("run_pre_rst", 8'hC3, 8'hFF, 1'b0, 8'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all("async_rst", 8'hA5, 8'h00, 1'b0, 8'd0);
        check_eq("async_rst_sat", {30'd0, s_cnt}, 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check_all("post_release", 8'h5A, 8'hFF, 1'b0, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_ff_bank.md
# jk_ff_bank

Parametrised multi-mode flip-flop bank, the multi-bit successor of the single-bit JK flip-flop. It holds WIDTH independent storage bits that share one clock, one reset, one enable and one mode select. Each bit behaves as a JK, SR, D or T flip-flop depending on the mode. The bank also reports per-bit change flags, a sticky SR-illegal error and a saturating change-event counter; it is used as a general control/status register primitive.

## Interface
Parameters:
- WIDTH, 8, number of storage bits (≥1)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- CNT_W, 8, width of change-event counter (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  update enable; 0 = everything holds
- mode  in  2  0=JK, 1=SR, 2=D, 3=T (applies to all bits)
- j  in  WIDTH  J / S / D / T input per bit
- k  in  WIDTH  K / R input per bit (ignored in D and T modes)
- clr_stat  in  1  synchronous clear of err and chg_cnt
- q  out  WIDTH  stored state
- q_n  out  WIDTH  ~q, combinational
- toggled  out  WIDTH  bits whose q changed at the last edge
- err  out  1  sticky: SR mode saw S=R=1 on some bit while en=1
- chg_cnt  out  CNT_W  number of enabled edges where any q bit changed; saturates

## Operation
- Next state per bit i when en=1:
  - JK: jk=00 hold, 01 q=0, 10 q=1, 11 q=~q
  - SR: 00 hold, 01 q=0, 10 q=1, 11 illegal → bit holds, err set
  - D: q=j[i]
  - T: j[i]=1 → q=~q, else hold
- en=0: q, err and chg_cnt hold; toggled=0. clr_stat is still honoured.
- toggled = q_next ^ q, registered on the same edge as q.
- chg_cnt increments by 1 on an enabled edge where toggled_next ≠ 0. It stops at 2^CNT_W−1 and never wraps.
- clr_stat with a simultaneous event:
  - err = illegal_this_edge (the set wins)
  - chg_cnt = 1 if the edge had a change, else 0
- A mode change takes effect on the next edge; no state is lost.

## Timing
- All registered outputs update on the clk rising edge: one-cycle latency from j/k/mode/en to q.
- Reset: rst low asynchronously forces q=RESET_VAL, toggled=0, err=0, chg_cnt=0, regardless of clk. Reset asserted mid-operation takes effect immediately.
- Reset release: the first rising edge with rst high performs a normal update.
- q_n is combinational from q; there are no other combinational input-to-output paths.
- Inputs are sampled at the rising edge; the testbench drives them on the falling edge.

## Structure
- Package jk_ff_pkg:
  - mode_e enum (MODE_JK=0, MODE_SR=1, MODE_D=2, MODE_T=3)
  - function next_bit(mode, q, j, k) returning next q and an illegal flag
- Sub-module jk_ff_cell: one bit.
  - Inputs: clk, rst, en, mode, j, k
  - Outputs: q, toggled, illegal
  - RESET_VAL bit as a parameter
  - Instantiated WIDTH times by a generate loop.
- Top level: OR-reduces illegal and toggled, and contains the err and chg_cnt registers.

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'hA5, rst=0 mid-clock → q=8'hA5, q_n=8'h5A, toggled=0, err=0, chg_cnt=0 immediately. After release with en=0 for 3 edges, all outputs are unchanged.
- JK mode from q=0, en=1, per-edge (j,k) on bit 0 = (1,0),(0,1),(0,0),(1,1),(1,1):
  - q[0] = 1,0,0,1,0
  - toggled[0] = 1,1,0,1,1
  - chg_cnt = 4
- SR mode, j=8'h03, k=8'h01:
  - bit0 holds, bit1 → 1, err=1.
  - Next edge: clr_stat=1 with j=k=0 → err=0.
  - clr_stat=1 together with another S=R=1 → err stays 1.
- D and T modes:
  - D with j=8'h3C → q=8'h3C.
  - Then T with j=8'hFF for two edges → q=8'hC3, then 8'h3C; toggled=8'hFF on both.
- Counter saturation: CNT_W=2, T mode, j=1 for 6 edges → chg_cnt = 1,2,3,3,3,3.
- Async reset mid-run: rst pulsed low between edges while counting → all outputs return to reset values without waiting for a clock edge.
